// File: rtl/asip_mem_pkg.sv
// asip_mem_pkg: shared FSM encoding and lane-index sizing for the memory stage
package asip_mem_pkg;
  localparam int VECTOR_SIZE = 4;
  localparam int LANE_BITS = $clog2(VECTOR_SIZE);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/mem_lane_collector.sv
// mem_lane_collector: per-lane write-enable register file gathering load lanes
module mem_lane_collector
  import asip_mem_pkg::*;
#(
  parameter int registerSize = 8,
  parameter int vectorSize = VECTOR_SIZE
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     clear,
  input  logic                                     wr_en,
  input  logic [LANE_BITS-1:0]                     wr_lane,
  input  logic [registerSize-1:0]                  wr_data,
  output logic [vectorSize-1:0][registerSize-1:0]  lanes_out
);
  logic [vectorSize-1:0][registerSize-1:0] lanes_q;
  always_ff @(posedge clk) begin
    if (reset || clear) lanes_q <= '0;
    else if (wr_en) lanes_q[wr_lane] <= wr_data;
  end
  assign lanes_out = lanes_q;
endmodule

// File: rtl/stage_memory.sv
// stage_memory: serializes scalar/vector loads and stores onto one lane-wide memory port
module stage_memory
  import asip_mem_pkg::*;
#(
  parameter int registerSize = 8,
  parameter int vectorSize = VECTOR_SIZE,
  parameter int addrWidth = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     valid_in,
  input  logic                                     memRead,
  input  logic                                     memWrite,
  input  logic                                     isVector,
  input  logic [addrWidth-1:0]                     address,
  input  logic [vectorSize-1:0][registerSize-1:0]  storeData,
  input  logic [vectorSize-1:0][registerSize-1:0]  aluResult,
  output logic                                     stall,
  output logic                                     valid_out,
  output logic [vectorSize-1:0][registerSize-1:0]  result_out,
  output logic [addrWidth-1:0]                     mem_addr,
  output logic [registerSize-1:0]                  mem_wdata,
  output logic                                     mem_we,
  input  logic [registerSize-1:0]                  mem_rdata
);
  mem_state_t state_q, state_d;
  logic [LANE_BITS-1:0] lane_q, lane_d, last_lane;
  logic [addrWidth-1:0] base_q;
  logic [vectorSize-1:0][registerSize-1:0] sdata_q, pass_q, lanes;
  logic write_q, vec_q, pass_v_q;
  logic accept, is_mem, accept_mem, in_access, last;
  assign is_mem = memRead | memWrite;
  assign accept = valid_in && (state_q == IDLE || state_q == DONE);
  assign accept_mem = accept && is_mem;
  assign in_access = state_q == ACCESS;
  assign last_lane = vec_q ? LANE_BITS'(vectorSize - 1) : '0;
  assign last = lane_q == last_lane;
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    unique case (state_q)
      ACCESS: begin
        state_d = last ? (write_q ? DONE : WAIT) : ACCESS;
        lane_d = lane_q + 1'b1;
      end
      WAIT: state_d = DONE;
      default: begin
        state_d = accept_mem ? ACCESS : IDLE;
        lane_d = accept_mem ? '0 : lane_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q <= '0;
      base_q <= '0;
      sdata_q <= '0;
      pass_q <= '0;
      write_q <= 1'b0;
      vec_q <= 1'b0;
      pass_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      pass_v_q <= accept && !is_mem;
      if (accept && !is_mem) pass_q <= aluResult;
      if (accept_mem) begin
        base_q <= address;
        sdata_q <= storeData;
        write_q <= memWrite;
        vec_q <= isVector;
      end
    end
  end
  // load data for lane N arrives while lane N+1 is issued; WAIT catches the final lane
  mem_lane_collector #(.registerSize(registerSize), .vectorSize(vectorSize)) u_collector (
    .clk(clk),
    .reset(reset),
    .clear(accept_mem && !memWrite),
    .wr_en((in_access && !write_q && lane_q != '0) || state_q == WAIT),
    .wr_lane(state_q == WAIT ? last_lane : lane_q - 1'b1),
    .wr_data(mem_rdata),
    .lanes_out(lanes)
  );
  assign stall = in_access || state_q == WAIT || accept_mem;
  assign valid_out = state_q == DONE || pass_v_q;
  assign result_out = state_q == DONE ? (write_q ? '0 : lanes) : (pass_v_q ? pass_q : '0);
  // a reset arriving mid-store must not let the in-flight lane reach memory
  assign mem_we = in_access && write_q && !reset;
  assign mem_addr = in_access ? base_q + addrWidth'(lane_q) : '0;
  assign mem_wdata = in_access && write_q ? sdata_q[lane_q] : '0;
endmodule
